down_four_timer: RTL and testbench
==================================

DOWN_FOUR_TIMER -- requirements
Module: down_four_timer

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the counter, load value and reload register.
REQ-002 Port clk  input  1  rising-edge clock; all state changes on posedge clk except reset.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port load  input  1  synchronous load strobe.
REQ-005 Port load_val  input  WIDTH  value captured on load.
REQ-006 Port start  input  1  synchronous start/restart strobe.
REQ-007 Port en  input  1  count enable; decrement occurs only when en=1.
REQ-008 Port auto_reload  input  1  1 = periodic mode; 0 = one-shot mode; sampled at terminal count.
REQ-009 Port count  output  WIDTH  current counter value, registered.
REQ-010 Port busy  output  1  high while state is RUN, decoded from the state register.
REQ-011 Port tc  output  1  terminal-count pulse, registered, one cycle wide.

Function
REQ-012 Internal state SHALL be count, reload_reg (WIDTH bits) and a 3-state FSM: IDLE, RUN, DONE.
REQ-013 Priority per edge SHALL be reset > load > start > en.
REQ-014 load=1 in any state: count=load_val, reload_reg=load_val, state=IDLE, tc=0; start and en are ignored that cycle.
REQ-015 IDLE: count holds; start=1 with count!=0 -> state=RUN, count unchanged; start=1 with count==0 -> ignored, remains IDLE.
REQ-016 RUN, en=0: count, state and reload_reg hold; tc=0.
REQ-017 RUN, en=1, count>1: count=count-1, tc=0.
REQ-018 RUN, en=1, count==1: count=0, tc=1 on the following cycle; auto_reload=0 -> state=DONE; auto_reload=1 -> state stays RUN.
REQ-019 RUN, en=1, count==0 (periodic mode only): count=reload_reg, tc=0; period = reload_reg+1 enabled cycles, with exactly one tc per period.
REQ-020 DONE: count=0 holds, busy=0; start=1 with reload_reg!=0 -> count=reload_reg, state=RUN; start=1 with reload_reg==0 -> ignored.
REQ-021 tc SHALL be 0 on every cycle not covered by REQ-018; it never stays high for two consecutive cycles.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH; count never wraps below 0; 0 is reached only through REQ-018.
REQ-023 start and en are ignored in IDLE for decrementing; no decrement occurs on the edge that transitions IDLE->RUN.
REQ-024 Unreachable FSM encodings SHALL transition to IDLE on the next edge with count, reload_reg and tc unchanged.

Reset
REQ-025 reset=1 SHALL immediately, without waiting for a clock edge, force count=0, reload_reg=0, state=IDLE, busy=0, tc=0.
REQ-026 While reset=1 all inputs are ignored; the first active edge after reset deasserts follows REQ-013..REQ-024.
REQ-027 A reset asserted mid-RUN SHALL abandon the count with no tc pulse.

Verification (WIDTH=4)
REQ-028 One-shot: load_val=5, pulse load, pulse start, en=1, auto_reload=0 -> count 5,5(busy=1),4,3,2,1,0 on successive edges; tc=1 for one cycle with count=0; busy=0 in the same cycle (DONE).
REQ-029 Pause: during the one-shot at count=3, hold en=0 for 4 cycles -> count stays 3 and tc=0; after en=1 resumes at 2,1,0.
REQ-030 Periodic: load_val=3, auto_reload=1, en=1 -> count 3,2,1,0,3,2,1,0,...; tc high once every 4 enabled cycles; busy stays 1.
REQ-031 Load override: at count=6 in RUN, load=1 and start=1 with load_val=9 -> next count=9, busy=0, tc=0 (IDLE); a later start resumes from 9.
REQ-032 Ignored start and restart: start immediately after reset -> stays IDLE with count=0; after a one-shot from 2 reaches DONE, start -> count=2, RUN.
REQ-033 Async reset: assert reset between clock edges at count=7 in RUN -> count=0, busy=0, tc=0 before the next edge, and tc does not pulse.

Source files
------------

// File: rtl/down_four_timer.sv
// Loadable down-counter timer with one-shot and periodic modes.
// Emits a one-cycle terminal-count pulse when the count reaches zero.
module down_four_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && count_q != '0)
                        state_d = RUN;
                end
                RUN: begin
                    if (en) begin
                        if (count_q == ONE) begin
                            count_d = '0;
                            tc_d    = 1'b1;
                            if (!auto_reload)
                                state_d = DONE;
                        end else if (count_q == '0) begin
                            // zero was reached in periodic mode: start next period
                            count_d = reload_q;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                DONE: begin
                    if (start && reload_q != '0) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tc_d    = tc_q;
                end
            endcase
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_four_timer.sv
// Directed self-checking bench for down_four_timer (WIDTH=4).
// Each step advances one clock edge and samples 1ns later.
module tb_down_four_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       tc;

    int passed = 0;
    int total = 0;

    down_four_timer #(.WIDTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .load_val(load_val),
        .start(start),
        .en(en),
        .auto_reload(auto_reload),
        .count(count),
        .busy(busy),
        .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk3(input string tag, input logic [3:0] c,
                        input logic b, input logic t);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".tc"}, 32'(tc), 32'(t));
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 chk3("rst_async", 4'd0, 1'b0, 1'b0);
        load = 1'b1; load_val = 4'd7; start = 1'b1; en = 1'b1;
        step();
        chk3("rst_hold", 4'd0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b0;
        reset = 1'b0;
        step();
        chk3("start_at_zero", 4'd0, 1'b0, 1'b0);
        start = 1'b0;

        // one-shot from 5 with pause at 3
        load = 1'b1; load_val = 4'd5;
        step();
        chk3("os_load", 4'd5, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1; en = 1'b1;
        step();
        chk3("os_start", 4'd5, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk3("os_4", 4'd4, 1'b1, 1'b0);
        step(); chk3("os_3", 4'd3, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk3("os_pause", 4'd3, 1'b1, 1'b0);
        end
        en = 1'b1;
        step(); chk3("os_2", 4'd2, 1'b1, 1'b0);
        step(); chk3("os_1", 4'd1, 1'b1, 1'b0);
        step(); chk3("os_0", 4'd0, 1'b0, 1'b1);
        step(); chk3("os_done", 4'd0, 1'b0, 1'b0);
        step(); chk3("os_done2", 4'd0, 1'b0, 1'b0);

        // one-shot from 2, then restart from DONE
        load = 1'b1; load_val = 4'd2;
        step(); chk3("rs_load", 4'd2, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1;
        step(); chk3("rs_start", 4'd2, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk3("rs_1", 4'd1, 1'b1, 1'b0);
        step(); chk3("rs_0", 4'd0, 1'b0, 1'b1);
        start = 1'b1;
        step(); chk3("rs_restart", 4'd2, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk3("rs_r1", 4'd1, 1'b1, 1'b0);

        // load overrides start while running
        load = 1'b1; load_val = 4'd8;
        step(); chk3("lo_load", 4'd8, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1;
        step(); chk3("lo_start", 4'd8, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk3("lo_7", 4'd7, 1'b1, 1'b0);
        step(); chk3("lo_6", 4'd6, 1'b1, 1'b0);
        load = 1'b1; start = 1'b1; load_val = 4'd9;
        step(); chk3("lo_override", 4'd9, 1'b0, 1'b0);
        load = 1'b0;
        step(); chk3("lo_resume", 4'd9, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk3("lo_8", 4'd8, 1'b1, 1'b0);

        // periodic mode from 3
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
        step(); chk3("pd_load", 4'd3, 1'b0, 1'b0);
        load = 1'b0; start = 1'b1;
        step(); chk3("pd_start", 4'd3, 1'b1, 1'b0);
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            step(); chk3("pd_2", 4'd2, 1'b1, 1'b0);
            step(); chk3("pd_1", 4'd1, 1'b1, 1'b0);
            step(); chk3("pd_0", 4'd0, 1'b1, 1'b1);
            step(); chk3("pd_3", 4'd3, 1'b1, 1'b0);
        end
        en = 1'b0;
        step(); chk3("pd_hold", 4'd3, 1'b1, 1'b0);
        en = 1'b1; auto_reload = 1'b0;

        // async reset mid-run at 7
        load = 1'b1; load_val = 4'd8;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); chk3("ar_7", 4'd7, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 chk3("ar_async", 4'd0, 1'b0, 1'b0);
        step(); chk3("ar_held", 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(); chk3("ar_after", 4'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
